// File: rtl/btb_assoc_nru.sv
// btb_assoc_nru: set-associative branch target buffer with in-place refresh, removal, flush and NRU replacement
module btb_assoc_nru #(
  parameter int NUM_SETS = 16,
  parameter int ASSOC    = 4,
  parameter int PC_W     = 31,
  parameter int OFFS_W   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            IN_flush,
  input  logic            IN_pcValid,
  input  logic [PC_W-1:0] IN_pc,
  output logic            OUT_valid,
  output logic            OUT_branchFound,
  output logic [PC_W-1:0] OUT_branchSrc,
  output logic [PC_W-1:0] OUT_branchDst,
  output logic            OUT_branchIsJump,
  output logic            OUT_branchCompr,
  output logic            OUT_multipleBranches,
  input  logic            IN_branchTaken,
  input  logic            IN_updValid,
  input  logic            IN_updRemove,
  input  logic [PC_W-1:0] IN_updSrc,
  input  logic [PC_W-1:0] IN_updDst,
  input  logic            IN_updIsJump,
  input  logic            IN_updCompr
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = PC_W - IDX_W - OFFS_W;
  localparam int WAY_W = ASSOC > 1 ? $clog2(ASSOC) : 1;

  logic [NUM_SETS-1:0][ASSOC-1:0]             valid_q, valid_d, used_q, used_d, jmp_q, jmp_d, cmp_q, cmp_d;
  logic [NUM_SETS-1:0][ASSOC-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [NUM_SETS-1:0][ASSOC-1:0][OFFS_W-1:0] offs_q, offs_d;
  logic [NUM_SETS-1:0][ASSOC-1:0][PC_W-1:0]   tgt_q, tgt_d;

  logic              ov_q, ov_d, of_q, of_d, ojmp_q, ojmp_d, ocmp_q, ocmp_d, omul_q, omul_d;
  logic [PC_W-1:0]   osrc_q, osrc_d, odst_q, odst_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [WAY_W-1:0]  r_way_q, r_way_d;

  logic [IDX_W-1:0]  l_idx, u_idx;
  logic [TAG_W-1:0]  l_tag, u_tag;
  logic [OFFS_W-1:0] l_off, u_off, l_best;
  logic              l_hit, l_multi, u_hit, inv_found, nu_found, upd_wr, mark;
  logic [WAY_W-1:0]  l_way, u_way, inv_way, nu_way, wr_way;

  assign l_idx = IN_pc[OFFS_W +: IDX_W];
  assign l_tag = IN_pc[PC_W-1 -: TAG_W];
  assign l_off = IN_pc[OFFS_W-1:0];
  assign u_idx = IN_updSrc[OFFS_W +: IDX_W];
  assign u_tag = IN_updSrc[PC_W-1 -: TAG_W];
  assign u_off = IN_updSrc[OFFS_W-1:0];

  // lookup: nearest qualifying branch at or after the fetch offset, plus a multi-hit flag
  always_comb begin
    l_hit = 1'b0;
    l_multi = 1'b0;
    l_way = '0;
    l_best = '0;
    for (int w = 0; w < ASSOC; w++)
      if (valid_q[l_idx][w] && tag_q[l_idx][w] == l_tag && offs_q[l_idx][w] >= l_off) begin
        l_multi = l_multi | l_hit;
        if (!l_hit || offs_q[l_idx][w] < l_best) begin
          l_way = WAY_W'(w);
          l_best = offs_q[l_idx][w];
        end
        l_hit = 1'b1;
      end
  end

  // registered response, zeroed on miss, idle or flush
  always_comb begin
    ov_d = IN_pcValid && !IN_flush;
    of_d = ov_d && l_hit;
    omul_d = ov_d && l_multi;
    osrc_d = of_d ? {l_tag, l_idx, l_best} : '0;
    odst_d = of_d ? tgt_q[l_idx][l_way] : '0;
    ojmp_d = of_d && jmp_q[l_idx][l_way];
    ocmp_d = of_d && cmp_q[l_idx][l_way];
    r_idx_d = l_idx;
    r_way_d = l_way;
  end

  // update probe: exact match, first invalid way, first not-recently-used way
  always_comb begin
    u_hit = 1'b0;
    u_way = '0;
    inv_found = 1'b0;
    inv_way = '0;
    nu_found = 1'b0;
    nu_way = '0;
    for (int w = 0; w < ASSOC; w++) begin
      if (valid_q[u_idx][w] && tag_q[u_idx][w] == u_tag && offs_q[u_idx][w] == u_off) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!valid_q[u_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (!used_q[u_idx][w] && !nu_found) begin
        nu_found = 1'b1;
        nu_way = WAY_W'(w);
      end
    end
    wr_way = u_hit ? u_way : inv_found ? inv_way : nu_found ? nu_way : '0;
    upd_wr = IN_updValid && !IN_flush && (!IN_updRemove || u_hit);
    mark = ov_q && of_q && (IN_branchTaken || ojmp_q) && !(upd_wr && u_idx == r_idx_q && wr_way == r_way_q);
  end

  // entry state: used marking first, then update, with flush overriding everything
  always_comb begin
    valid_d = valid_q;
    used_d = used_q;
    jmp_d = jmp_q;
    cmp_d = cmp_q;
    tag_d = tag_q;
    offs_d = offs_q;
    tgt_d = tgt_q;
    if (mark) used_d[r_idx_q][r_way_q] = 1'b1;
    if (IN_flush) begin
      valid_d = '0;
      used_d = '0;
    end else if (IN_updValid && IN_updRemove) begin
      if (u_hit) valid_d[u_idx][u_way] = 1'b0;
    end else if (IN_updValid) begin
      tgt_d[u_idx][wr_way] = IN_updDst;
      jmp_d[u_idx][wr_way] = IN_updIsJump;
      cmp_d[u_idx][wr_way] = IN_updCompr;
      if (!u_hit) begin
        if (!inv_found && !nu_found) used_d[u_idx] = '0;
        valid_d[u_idx][wr_way] = 1'b1;
        used_d[u_idx][wr_way] = 1'b0;
        tag_d[u_idx][wr_way] = u_tag;
        offs_d[u_idx][wr_way] = u_off;
      end
    end
  end

  // control state and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      used_q <= '0;
      ov_q <= 1'b0;
      of_q <= 1'b0;
      omul_q <= 1'b0;
      osrc_q <= '0;
      odst_q <= '0;
      ojmp_q <= 1'b0;
      ocmp_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      used_q <= used_d;
      ov_q <= ov_d;
      of_q <= of_d;
      omul_q <= omul_d;
      osrc_q <= osrc_d;
      odst_q <= odst_d;
      ojmp_q <= ojmp_d;
      ocmp_q <= ocmp_d;
    end
  end

  // payload storage, only observed through valid entries
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    offs_q <= offs_d;
    tgt_q <= tgt_d;
    jmp_q <= jmp_d;
    cmp_q <= cmp_d;
    r_idx_q <= r_idx_d;
    r_way_q <= r_way_d;
  end

  assign OUT_valid = ov_q;
  assign OUT_branchFound = of_q;
  assign OUT_branchSrc = osrc_q;
  assign OUT_branchDst = odst_q;
  assign OUT_branchIsJump = ojmp_q;
  assign OUT_branchCompr = ocmp_q;
  assign OUT_multipleBranches = omul_q;
endmodule

// File: tb/tb_btb_assoc_nru.sv
// tb_btb_assoc_nru: directed scoreboard bench for the NRU branch target buffer
module tb_btb_assoc_nru;
  logic        clk = 1'b0;
  logic        rst;
  logic        IN_flush, IN_pcValid, IN_branchTaken, IN_updValid, IN_updRemove, IN_updIsJump, IN_updCompr;
  logic [30:0] IN_pc, IN_updSrc, IN_updDst;
  logic        OUT_valid, OUT_branchFound, OUT_branchIsJump, OUT_branchCompr, OUT_multipleBranches;
  logic [30:0] OUT_branchSrc, OUT_branchDst;

  typedef struct packed {
    logic [30:0] pc;
    logic        f;
    logic [30:0] s;
    logic [30:0] d;
    logic        j;
    logic        c;
    logic        m;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  logic tk_pend = 1'b0;

  btb_assoc_nru dut (
    .clk(clk), .rst(rst), .IN_flush(IN_flush), .IN_pcValid(IN_pcValid), .IN_pc(IN_pc),
    .OUT_valid(OUT_valid), .OUT_branchFound(OUT_branchFound), .OUT_branchSrc(OUT_branchSrc),
    .OUT_branchDst(OUT_branchDst), .OUT_branchIsJump(OUT_branchIsJump), .OUT_branchCompr(OUT_branchCompr),
    .OUT_multipleBranches(OUT_multipleBranches), .IN_branchTaken(IN_branchTaken),
    .IN_updValid(IN_updValid), .IN_updRemove(IN_updRemove), .IN_updSrc(IN_updSrc), .IN_updDst(IN_updDst),
    .IN_updIsJump(IN_updIsJump), .IN_updCompr(IN_updCompr)
  );

  always #5 clk = ~clk;

  // monitor: every presented response is matched against the oldest expectation
  always @(negedge clk) begin
    if (OUT_valid) begin
      exp_t e;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_response got valid=1 src=%h want no response", OUT_branchSrc);
      end else begin
        e = q.pop_front();
        if ({OUT_branchFound, OUT_branchSrc, OUT_branchDst, OUT_branchIsJump, OUT_branchCompr, OUT_multipleBranches}
            !== {e.f, e.s, e.d, e.j, e.c, e.m}) begin
          bad++;
          $display("FAIL lookup pc=%h got f=%0d src=%h dst=%h j=%0d c=%0d m=%0d want f=%0d src=%h dst=%h j=%0d c=%0d m=%0d",
                   e.pc, OUT_branchFound, OUT_branchSrc, OUT_branchDst, OUT_branchIsJump, OUT_branchCompr,
                   OUT_multipleBranches, e.f, e.s, e.d, e.j, e.c, e.m);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc(input logic pv, input logic [30:0] pc, input logic tk, input logic uv, input logic ur,
                     input logic [30:0] us, input logic [30:0] ud, input logic uj, input logic uc, input logic fl);
    @(negedge clk);
    IN_branchTaken = tk_pend;
    tk_pend = pv & tk;
    IN_pcValid = pv;
    IN_pc = pc;
    IN_updValid = uv;
    IN_updRemove = ur;
    IN_updSrc = us;
    IN_updDst = ud;
    IN_updIsJump = uj;
    IN_updCompr = uc;
    IN_flush = fl;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ins(input logic [30:0] s, input logic [30:0] d, input logic j, input logic c);
    cyc(0, 0, 0, 1, 0, s, d, j, c, 0);
  endtask

  task automatic rem(input logic [30:0] s);
    cyc(0, 0, 0, 1, 1, s, 0, 0, 0, 0);
  endtask

  task automatic look(input logic [30:0] pc, input logic tk, input logic f, input logic [30:0] s,
                      input logic [30:0] d, input logic j, input logic c, input logic m);
    q.push_back('{pc, f, s, d, j, c, m});
    cyc(1, pc, tk, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic miss(input logic [30:0] pc);
    look(pc, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    {IN_flush, IN_pcValid, IN_branchTaken, IN_updValid, IN_updRemove, IN_updIsJump, IN_updCompr} = '0;
    IN_pc = '0;
    IN_updSrc = '0;
    IN_updDst = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'({OUT_valid, OUT_branchFound, OUT_branchSrc, OUT_branchDst, OUT_branchIsJump,
                               OUT_branchCompr, OUT_multipleBranches}), 128'd0);
    rst = 1'b0;
    ins(31'h12, 31'h100, 0, 1);
    look(31'h10, 0, 1, 31'h12, 31'h100, 0, 1, 0);
    miss(31'h16);
    ins(31'h15, 31'h140, 0, 0);
    look(31'h10, 0, 1, 31'h12, 31'h100, 0, 1, 1);
    look(31'h13, 0, 1, 31'h15, 31'h140, 0, 0, 0);
    ins(31'h12, 31'h200, 0, 1);
    rem(31'h15);
    look(31'h10, 0, 1, 31'h12, 31'h200, 0, 1, 0);
    ins(31'h92, 31'h300, 0, 0);
    ins(31'h112, 31'h400, 0, 0);
    ins(31'h192, 31'h500, 0, 0);
    look(31'h10, 1, 1, 31'h12, 31'h200, 0, 1, 0);
    look(31'h90, 1, 1, 31'h92, 31'h300, 0, 0, 0);
    look(31'h110, 0, 1, 31'h112, 31'h400, 0, 0, 0);
    look(31'h190, 0, 1, 31'h192, 31'h500, 0, 0, 0);
    ins(31'h212, 31'h600, 0, 0);
    miss(31'h110);
    look(31'h10, 0, 1, 31'h12, 31'h200, 0, 1, 0);
    look(31'h90, 0, 1, 31'h92, 31'h300, 0, 0, 0);
    look(31'h210, 1, 1, 31'h212, 31'h600, 0, 0, 0);
    look(31'h190, 1, 1, 31'h192, 31'h500, 0, 0, 0);
    idle();
    ins(31'h292, 31'h700, 0, 0);
    miss(31'h10);
    look(31'h290, 1, 1, 31'h292, 31'h700, 0, 0, 0);
    idle();
    ins(31'h392, 31'h800, 0, 0);
    miss(31'h90);
    look(31'h290, 0, 1, 31'h292, 31'h700, 0, 0, 0);
    look(31'h210, 0, 1, 31'h212, 31'h600, 0, 0, 0);
    look(31'h190, 0, 1, 31'h192, 31'h500, 0, 0, 0);
    look(31'h390, 0, 1, 31'h392, 31'h800, 0, 0, 0);
    rem(31'h292);
    miss(31'h290);
    ins(31'h12, 31'h100, 0, 1);
    look(31'h10, 0, 1, 31'h12, 31'h100, 0, 1, 0);
    rem(31'h12);
    miss(31'h10);
    rem(31'h312);
    look(31'h390, 0, 1, 31'h392, 31'h800, 0, 0, 0);
    look(31'h210, 0, 1, 31'h212, 31'h600, 0, 0, 0);
    cyc(1, 31'h390, 0, 1, 0, 31'h412, 31'h900, 0, 0, 1);
    idle();
    chk("flush_suppresses_valid", 128'(OUT_valid), 128'd0);
    miss(31'h410);
    miss(31'h390);
    miss(31'h210);
    miss(31'h190);
    cyc(1, 31'h10, 0, 1, 0, 31'h12, 31'h100, 0, 1, 0);
    q.push_back('{31'h10, 1'b0, 31'h0, 31'h0, 1'b0, 1'b0, 1'b0});
    look(31'h10, 0, 1, 31'h12, 31'h100, 0, 1, 0);
    ins(31'h2D, 31'h555, 0, 1);
    ins(31'h2A, 31'h444, 1, 0);
    look(31'h28, 0, 1, 31'h2A, 31'h444, 1, 0, 1);
    look(31'h2B, 0, 1, 31'h2D, 31'h555, 0, 1, 0);
    @(negedge clk);
    IN_branchTaken = tk_pend;
    tk_pend = 1'b0;
    rst = 1'b1;
    IN_pcValid = 1'b1;
    IN_pc = 31'h10;
    @(negedge clk);
    chk("midstream_reset_outputs", 128'({OUT_valid, OUT_branchFound, OUT_branchSrc, OUT_branchDst, OUT_branchIsJump,
                                         OUT_branchCompr, OUT_multipleBranches}), 128'd0);
    rst = 1'b0;
    IN_pcValid = 1'b0;
    IN_branchTaken = 1'b0;
    miss(31'h10);
    miss(31'h28);
    idle();
    idle();
    idle();
    chk("scoreboard_drained", 128'(q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
